uart_peripheral: RTL and testbench

Memory-mapped 8N1 UART that attaches to one device slot of the bus hub alongside memory, SPRAM, parallel port and GPU. It drives the board serial TX pin from a TX FIFO filled by CPU stores. It optionally receives bytes on the RX pin into a single holding register. It decodes its own address window and answers with the same ready/active handshake as the other bus devices.

---
 rtl/uart_peripheral.sv | 269 ++++++++++++++++++++++++++
 tb/tb_uart_peripheral.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART: TX FIFO feeding a serial shifter, optional receive holding register.
// Define UART_RX_EN to build the receiver (RX synchroniser, rx_data, RXV/RXOVR/RXFERR).
module uart_peripheral #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_F000,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        wen,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        active,
    output logic        txd,
    input  logic        rxd
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [15:0]   div_reg, div_merge, div_next;
    logic          txovf_reg, ready_reg;
    logic [31:0]   rdata_reg, read_value;

    tx_state_t   tx_state_reg;
    logic [15:0] tx_cnt_reg;
    logic [2:0]  tx_bit_reg;
    logic [7:0]  tx_shift_reg;
    logic        txd_reg;

    logic req, wr_req, rd_req, sel_data, sel_status, sel_div;
    logic fifo_full, fifo_empty, push, pop, tx_busy, bit_done;
    logic [2:0] status_clear;
    logic rxv, rxovr, rxferr;
    logic [7:0] rx_data;

    assign active     = addr[31:4] == BASE_ADDR[31:4];
    assign req        = (wen | ren) & active & ~ready_reg;
    assign wr_req     = req & wen;
    assign rd_req     = req & ~wen;
    assign sel_data   = addr[3:2] == 2'd0;
    assign sel_status = addr[3:2] == 2'd1;
    assign sel_div    = addr[3:2] == 2'd2;

    assign fifo_full  = count_reg == FULL_COUNT;
    assign fifo_empty = count_reg == '0;
    assign push       = wr_req & sel_data & wmask[0] & ~fifo_full;
    assign bit_done   = tx_cnt_reg == 16'd0;
    // Popping straight out of the final stop-bit cycle keeps back-to-back frames gapless.
    assign pop        = ~fifo_empty & ((tx_state_reg == TX_IDLE) | ((tx_state_reg == TX_STOP) & bit_done));
    assign tx_busy    = tx_state_reg != TX_IDLE;
    assign status_clear = {3{wr_req & sel_status & wmask[0]}} & wdata[6:4];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_div_byte
            assign div_merge[gi*8 +: 8] = wmask[gi] ? wdata[gi*8 +: 8] : div_reg[gi*8 +: 8];
        end
    endgenerate
    assign div_next = (div_merge < 16'd2) ? 16'd2 : div_merge;

    always_comb begin
        read_value = '0;
        case (addr[3:2])
            2'd0:    read_value = {24'h0, rx_data};
            2'd1:    read_value = {25'h0, rxferr, txovf_reg, rxovr, rxv, tx_busy, fifo_empty, fifo_full};
            2'd2:    read_value = {16'h0, div_reg};
            default: read_value = {{(32-CW){1'b0}}, count_reg};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_reg <= 1'b0;
            rdata_reg <= '0;
            div_reg   <= DEFAULT_DIV;
            txovf_reg <= 1'b0;
        end else begin
            ready_reg <= req;
            rdata_reg <= rd_req ? read_value : '0;
            if (wr_req & sel_div)
                div_reg <= div_next;
            if (wr_req & sel_data & wmask[0] & fifo_full)
                txovf_reg <= 1'b1;
            else if (status_clear[1])
                txovf_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            txd_reg      <= 1'b1;
        end else if (pop) begin
            tx_state_reg <= TX_START;
            tx_shift_reg <= fifo_mem[rd_ptr_reg];
            tx_cnt_reg   <= div_reg;
            txd_reg      <= 1'b0;
        end else begin
            case (tx_state_reg)
                TX_IDLE: txd_reg <= 1'b1;
                TX_START: begin
                    if (bit_done) begin
                        tx_state_reg <= TX_DATA;
                        tx_bit_reg   <= '0;
                        txd_reg      <= tx_shift_reg[0];
                        tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                        tx_cnt_reg   <= div_reg;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (bit_done) begin
                        tx_cnt_reg <= div_reg;
                        if (tx_bit_reg == 3'd7) begin
                            tx_state_reg <= TX_STOP;
                            txd_reg      <= 1'b1;
                        end else begin
                            tx_bit_reg   <= tx_bit_reg + 3'd1;
                            txd_reg      <= tx_shift_reg[0];
                            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg - 16'd1;
                    end
                end
                default: begin
                    if (bit_done) begin
                        tx_state_reg <= TX_IDLE;
                        txd_reg      <= 1'b1;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg - 16'd1;
                    end
                end
            endcase
        end
    end

`ifdef UART_RX_EN
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   rx_state_reg;
    logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic [15:0] rx_cnt_reg;
    logic [2:0]  rx_bit_reg;
    logic [7:0]  rx_shift_reg, rx_data_reg;
    logic        rxv_reg, rxovr_reg, rxferr_reg;

    // Clears are written before the receiver's sets so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            rxv_reg      <= 1'b0;
            rxovr_reg    <= 1'b0;
            rxferr_reg   <= 1'b0;
        end else begin
            rx_meta_reg <= rxd;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            if (rd_req & sel_data) rxv_reg    <= 1'b0;
            if (status_clear[0])   rxovr_reg  <= 1'b0;
            if (status_clear[2])   rxferr_reg <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    if (rx_prev_reg & ~rx_sync_reg) begin
                        rx_state_reg <= RX_START;
                        rx_cnt_reg   <= div_reg >> 1;
                    end
                end
                RX_START: begin
                    if (rx_cnt_reg == 16'd0) begin
                        rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
                        rx_cnt_reg   <= div_reg;
                        rx_bit_reg   <= '0;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_reg == 16'd0) begin
                        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                        rx_cnt_reg   <= div_reg;
                        rx_bit_reg   <= rx_bit_reg + 3'd1;
                        if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg - 16'd1;
                    end
                end
                default: begin
                    if (rx_cnt_reg == 16'd0) begin
                        rx_state_reg <= RX_IDLE;
                        if (!rx_sync_reg) begin
                            rxferr_reg <= 1'b1;
                        end else if (rxv_reg) begin
                            rxovr_reg <= 1'b1;
                        end else begin
                            rx_data_reg <= rx_shift_reg;
                            rxv_reg     <= 1'b1;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg - 16'd1;
                    end
                end
            endcase
        end
    end

    assign rx_data = rx_data_reg;
    assign rxv     = rxv_reg;
    assign rxovr   = rxovr_reg;
    assign rxferr  = rxferr_reg;
    logic unused_cfg;
    assign unused_cfg = 1'b0;
`else
    assign rx_data = '0;
    assign rxv     = 1'b0;
    assign rxovr   = 1'b0;
    assign rxferr  = 1'b0;
    logic unused_cfg;
    assign unused_cfg = ^{rxd, status_clear[0], status_clear[2]};
`endif

    logic unused_bits;
    assign unused_bits = ^{wdata[31:16], addr[1:0], wmask[3:2], unused_cfg};

    assign ready = ready_reg;
    assign rdata = rdata_reg;
    assign txd   = txd_reg;
endmodule

// File: tb/tb_uart_peripheral.sv
// Bench for uart_peripheral: frame-level reference model compared every cycle, plus literal checks.
module tb_uart_peripheral;
    localparam logic [31:0] BASE = 32'h0000_F000;
    localparam logic [31:0] A_DATA = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_DIV  = BASE + 32'h8;
    localparam logic [31:0] A_LVL  = BASE + 32'hC;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  wmask = '0;
    logic        wen = 1'b0, ren = 1'b0, rxd = 1'b1;
    logic [31:0] rdata;
    logic        ready, active, txd;

    int tests = 0, fails = 0;
    bit checking = 0;

    uart_peripheral #(.BASE_ADDR(BASE), .FIFO_DEPTH(16), .DEFAULT_DIV(16'd103)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wmask(wmask),
        .wen(wen), .ren(ren), .rdata(rdata), .ready(ready), .active(active),
        .txd(txd), .rxd(rxd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: register contents, queued bytes and the frame currently on the wire.
    logic [7:0]  m_q[$];
    int          m_div = 103, m_busy_left = 0, m_frame_div = 0;
    logic [9:0]  m_frame = '1;
    logic        m_txovf = 0, m_rxv = 0, m_rxovr = 0, m_rxferr = 0;
    logic [7:0]  m_rxdata = '0;
    logic        m_ready = 0, m_txd = 1;
    logic [31:0] m_rdata = '0;

    function automatic logic [31:0] model_read(input logic [1:0] sel);
        case (sel)
            2'd0:    return {24'h0, m_rxdata};
            2'd1:    return {25'h0, m_rxferr, m_txovf, m_rxovr, m_rxv, m_busy_left > 0,
                             m_q.size() == 0, m_q.size() == 16};
            2'd2:    return 32'(m_div);
            default: return 32'(m_q.size());
        endcase
    endfunction

    always @(posedge clk) begin : model_step
        logic req, full_pre;
        logic [31:0] rv;
        logic [15:0] nd;
        if (rst) begin
            m_q.delete();
            m_div = 103; m_busy_left = 0; m_txovf = 0;
            m_rxv = 0; m_rxovr = 0; m_rxferr = 0; m_rxdata = '0;
            m_ready = 0; m_rdata = '0; m_txd = 1;
        end else begin
            req = (wen || ren) && (addr[31:4] == BASE[31:4]) && !m_ready;
            rv = (req && !wen) ? model_read(addr[3:2]) : 32'h0;
            full_pre = (m_q.size() == 16);
            if (m_busy_left > 0) m_busy_left--;
            if (m_busy_left == 0 && m_q.size() > 0) begin
                m_frame = {1'b1, m_q.pop_front(), 1'b0};
                m_frame_div = m_div;
                m_busy_left = 10 * (m_div + 1);
            end
            if (req && wen) begin
                case (addr[3:2])
                    2'd0: if (wmask[0]) begin
                        if (full_pre) m_txovf = 1;
                        else m_q.push_back(wdata[7:0]);
                    end
                    2'd1: if (wmask[0]) begin
                        if (wdata[4]) m_rxovr = 0;
                        if (wdata[5]) m_txovf = 0;
                        if (wdata[6]) m_rxferr = 0;
                    end
                    2'd2: begin
                        nd = 16'(m_div);
                        if (wmask[0]) nd[7:0] = wdata[7:0];
                        if (wmask[1]) nd[15:8] = wdata[15:8];
                        m_div = (nd < 16'd2) ? 2 : int'(nd);
                    end
                    default: ;
                endcase
            end
            if (req && !wen && addr[3:2] == 2'd0) m_rxv = 0;
            m_ready = req;
            m_rdata = rv;
            m_txd = (m_busy_left > 0)
                  ? m_frame[(10 * (m_frame_div + 1) - m_busy_left) / (m_frame_div + 1)] : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("ready", {31'h0, ready}, {31'h0, m_ready});
            check("rdata", rdata, m_rdata);
            check("txd", {31'h0, txd}, {31'h0, m_txd});
            check("active", {31'h0, active}, {31'h0, addr[31:4] == BASE[31:4]});
        end
    end

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       input logic w, input logic r, output logic [31:0] q);
        @(negedge clk);
        addr = a; wdata = d; wmask = m; wen = w; ren = r;
        @(negedge clk);
        q = rdata;
        wen = 0; ren = 0; wmask = '0;
        if (w) $display("[TB] WR addr=0x%08h data=0x%08h mask=%b", a, d, m);
        else   $display("[TB] RD addr=0x%08h -> 0x%08h", a, q);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] q;
        bus(a, d, m, 1'b1, 1'b0, q);
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] q;
        bus(a, 32'h0, 4'h0, 1'b0, 1'b1, q);
        check(name, q, exp);
    endtask

`ifdef UART_RX_EN
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = f[i];
            repeat (7) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        if (!stop_bit) m_rxferr = 1;
        else if (m_rxv) m_rxovr = 1;
        else begin m_rxdata = b; m_rxv = 1; end
        $display("[TB] RX frame data=0x%02h stop=%b", b, stop_bit);
    endtask
`endif

    initial begin : stimulus
        logic [9:0] a5_bits;
        logic [31:0] q;
        a5_bits = 10'b1_1010_0101_0;
        repeat (3) @(posedge clk);
        checking = 1;
        @(negedge clk);
        rst = 0;

        // Reset state
        check("reset_txd", {31'h0, txd}, 32'h1);
        rd_check("reset_status", A_STAT, 32'h0000_0002);
        rd_check("reset_txlvl", A_LVL, 32'h0);
        rd_check("reset_div", A_DIV, 32'd103);

        // Single frame 0xA5 at DIV=3
        wr(A_DIV, 32'd3, 4'b0011);
        wr(A_DATA, 32'hA5, 4'b0001);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("a5_bit%0d", i), {31'h0, txd}, {31'h0, a5_bits[i]});
            repeat (4) @(negedge clk);
        end
        rd_check("a5_idle_status", A_STAT, 32'h0000_0002);

        // DIV clamping and byte masks
        wr(A_DIV, 32'd0, 4'b0011);
        rd_check("div_clamp", A_DIV, 32'd2);
        wr(A_DIV, 32'hFFFF_0067, 4'b0011);
        wr(A_DIV, 32'h0000_0100, 4'b0010);
        rd_check("div_bytemask", A_DIV, 32'h0000_0167);

        // Fill FIFO: 17 writes, first is popped, 16 remain
        for (int i = 0; i < 17; i++) wr(A_DATA, 32'(8'h10 + i), 4'b0001);
        rd_check("fill_txlvl", A_LVL, 32'd16);
        rd_check("fill_status", A_STAT, 32'h0000_0005);
        wr(A_DATA, 32'hEE, 4'b0001);
        wr(A_DATA, 32'hEF, 4'b0001);
        rd_check("ovf_status", A_STAT, 32'h0000_0025);
        rd_check("ovf_txlvl", A_LVL, 32'd16);
        wr(A_STAT, 32'h20, 4'b0001);
        rd_check("ovf_cleared", A_STAT, 32'h0000_0005);

        // Reset mid-frame
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("midreset_txd", {31'h0, txd}, 32'h1);
        rd_check("midreset_txlvl", A_LVL, 32'h0);
        rd_check("midreset_div", A_DIV, 32'd103);

        // Outside the window: no active, no ready, no push
        @(negedge clk);
        addr = BASE + 32'h10; wdata = 32'h99; wmask = 4'b0001; wen = 1; ren = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("oow_active", {31'h0, active}, 32'h0);
            check("oow_ready", {31'h0, ready}, 32'h0);
        end
        wen = 0; ren = 0; wmask = '0;
        rd_check("oow_txlvl", A_LVL, 32'h0);

        // Back-to-back frames at the minimum divider, checked by the model every cycle
        wr(A_DIV, 32'd1, 4'b0001);
        wr(A_DATA, 32'h81, 4'b0001);
        wr(A_DATA, 32'h7E, 4'b0001);
        wr(A_DATA, 32'h00, 4'b0001);
        repeat (110) @(negedge clk);
        rd_check("b2b_status", A_STAT, 32'h0000_0002);

        // wen and ren together behave as a write
        bus(A_DATA, 32'h5A, 4'b0001, 1'b1, 1'b1, q);
        check("wr_rd_rdata", q, 32'h0);
        repeat (40) @(negedge clk);

`ifdef UART_RX_EN
        wr(A_DIV, 32'd7, 4'b0011);
        send_frame(8'h3C, 1'b1);
        rd_check("rx_status_rxv", A_STAT, 32'h0000_000A);
        rd_check("rx_data", A_DATA, 32'h0000_003C);
        rd_check("rx_status_clr", A_STAT, 32'h0000_0002);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        rd_check("rx_ovr_status", A_STAT, 32'h0000_001A);
        rd_check("rx_ovr_data", A_DATA, 32'h0000_0011);
        send_frame(8'h55, 1'b0);
        rd_check("rx_ferr_status", A_STAT, 32'h0000_0052);
        wr(A_STAT, 32'h70, 4'b0001);
        rd_check("rx_flags_clr", A_STAT, 32'h0000_0002);
`else
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        rd_check("norx_data", A_DATA, 32'h0);
        rd_check("norx_status", A_STAT, 32'h0000_0002);
`endif

        repeat (4) @(negedge clk);
        checking = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
